// File: rtl/alsu_pkg.sv
// Shared constants for the ALSU seven-segment display driver.
// Glyph table (active-low {g,f,e,d,c,b,a}), special glyphs, width helper.
package alsu_pkg;

  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Bits needed to count 0..n-1 (at least one).
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl.sv
// Digit scan: refresh counter, digit index, active-low one-hot anode select.
// Ports: clk, rst, en (scan runs), next_idx (index after this edge), sel.
module seg_scan_ctrl
  import alsu_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  output logic [cnt_w(DIGITS)-1:0]   next_idx,
  output logic [DIGITS-1:0]          sel
);

  localparam int IW = cnt_w(DIGITS);
  localparam int RW = cnt_w(REFRESH_DIV);

  logic [RW-1:0] rcnt;
  logic [IW-1:0] idx;
  logic          wrap;

  // The index the output register latches is the one in force after
  // the edge, so a digit switch and a capture on the same edge show
  // the new digit with the old register contents for one cycle.
  always_comb begin
    wrap     = en && (rcnt == RW'(REFRESH_DIV - 1));
    next_idx = idx;
    if (wrap)
      next_idx = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    sel           = '1;
    sel[next_idx] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt <= '0;
      idx  <= '0;
    end else if (en) begin
      rcnt <= wrap ? '0 : rcnt + 1'b1;
      idx  <= next_idx;
    end
  end

endmodule

// File: rtl/alsu_seg_mux_driver.sv
// Multiplexed seven-segment driver for an ALSU result with error blink.
// Ports: clk, rst, valid, data, hold, blank_lz -> anode, cathode, err.
module alsu_seg_mux_driver
  import alsu_pkg::*;
#(
  parameter int DATA_W      = 6,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  input  logic              hold,
  input  logic              blank_lz,
  output logic [DIGITS-1:0] anode,
  output logic [6:0]        cathode,
  output logic              err
);

  localparam int NW = 4 * DIGITS;
  localparam int IW = cnt_w(DIGITS);
  localparam int BW = cnt_w(BLINK_DIV);

  logic [NW-1:0]     disp;
  logic              run;
  logic              phase;
  logic [BW-1:0]     bcnt;
  logic [IW-1:0]     next_idx;
  logic [DIGITS-1:0] sel;
  logic [NW-1:0]     upper;
  logic [6:0]        seg;

  seg_scan_ctrl #(
    .DIGITS      (DIGITS),
    .REFRESH_DIV (REFRESH_DIV)
  ) u_scan (
    .clk      (clk),
    .rst      (rst),
    .en       (run),
    .next_idx (next_idx),
    .sel      (sel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp <= '0;
      err  <= 1'b0;
    end else if (!hold) begin
      if (valid) begin
        disp <= NW'(data);
        err  <= 1'b0;
      end else begin
        err <= 1'b1;
      end
    end
  end

  // run holds the scan and outputs dark for one edge after reset
  // release, so the first lit digit appears on the second edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run   <= 1'b0;
      bcnt  <= '0;
      phase <= 1'b0;
    end else begin
      run <= 1'b1;
      if (bcnt == BW'(BLINK_DIV - 1)) begin
        bcnt  <= '0;
        phase <= ~phase;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
    end
  end

  // upper == 0 means this digit and every digit above it are zero.
  always_comb begin
    upper = disp >> {next_idx, 2'b00};
    seg   = GLYPH[upper[3:0]];
    if (err)
      seg = (next_idx == IW'(DIGITS - 1)) ? SEG_E : SEG_DASH;
    else if (blank_lz && next_idx != '0 && upper == '0)
      seg = SEG_BLANK;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anode   <= '1;
      cathode <= SEG_BLANK;
    end else if (!run) begin
      anode   <= '1;
      cathode <= SEG_BLANK;
    end else begin
      anode   <= (err && phase) ? '1 : sel;
      cathode <= seg;
    end
  end

endmodule

// File: tb/tb_alsu_seg_mux_driver.sv
// Randomised bench for alsu_seg_mux_driver with a closed-form model.
// Small parameters: DATA_W=6, DIGITS=2, REFRESH_DIV=4, BLINK_DIV=8.
module tb_alsu_seg_mux_driver;

  localparam int DW = 6;
  localparam int D  = 2;
  localparam int R  = 4;
  localparam int B  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid = 1'b1;
  logic [DW-1:0] data = '0;
  logic          hold = 1'b0;
  logic          blank_lz = 1'b0;
  logic [D-1:0]  anode;
  logic [6:0]    cathode;
  logic          err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] glyph [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  alsu_seg_mux_driver #(
    .DATA_W      (DW),
    .DIGITS      (D),
    .REFRESH_DIV (R),
    .BLINK_DIV   (B)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .valid    (valid),
    .data     (data),
    .hold     (hold),
    .blank_lz (blank_lz),
    .anode    (anode),
    .cathode  (cathode),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act,
                       input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: e counts edges since reset release. Edge 1 is dark; from
  // edge 2 the digit shown after edge e is ((e-1)/R)%D, and the blink
  // phase in force before edge e is ((e-1)/B)%2.
  int         e = 0;
  int         m_idx;
  int         m_ph;
  logic [7:0] m_disp = '0;
  logic       m_err = 1'b0;
  logic [7:0] up;
  logic [D-1:0] ea;
  logic [6:0] ec;

  always @(posedge clk) begin
    if (rst) begin
      e = 0;
      m_disp = '0;
      m_err = 1'b0;
      ea = '1;
      ec = 7'h7F;
    end else begin
      e++;
      if (e == 1) begin
        ea = '1;
        ec = 7'h7F;
      end else begin
        m_idx = ((e - 1) / R) % D;
        m_ph  = ((e - 1) / B) % 2;
        ea = (m_err && m_ph == 1) ? '1 : ~(D'(1) << m_idx);
        up = m_disp >> (4 * m_idx);
        if (m_err)
          ec = (m_idx == D - 1) ? 7'h06 : 7'h3F;
        else if (blank_lz && m_idx > 0 && up == 0)
          ec = 7'h7F;
        else
          ec = glyph[up[3:0]];
      end
      if (!hold) begin
        if (valid) begin
          m_disp = {2'b00, data};
          m_err = 1'b0;
        end else begin
          m_err = 1'b1;
        end
      end
    end
    #1;
    check("model_anode", int'(anode), int'(ea));
    check("model_cathode", int'(cathode), int'(ec));
    check("model_err", int'(err), int'(m_err));
  end

  // Wait for anode to move into value t (bounded).
  task automatic wait_an(input logic [D-1:0] t);
    int k = 0;
    while (anode == t && k < 40) begin
      @(negedge clk);
      k++;
    end
    while (anode != t && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_anode: got %0b expected %0b", anode, t);
    end
  endtask

  task automatic wait_change();
    logic [D-1:0] p = anode;
    int k = 0;
    while (anode == p && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_change: anode stuck at %0b", anode);
    end
  endtask

  task automatic count_dark(input int cycles, input int exp,
                            input string name);
    int c = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (anode == '1) c++;
    end
    check(name, c, exp);
  endtask

  initial begin
    int cnt;
    logic [D-1:0] a_new;
    repeat (2) @(negedge clk);
    check("reset_anode", int'(anode), 3);
    check("reset_cathode", int'(cathode), 'h7F);
    check("reset_err", int'(err), 0);

    rst = 1'b0;
    @(negedge clk);
    check("release_dark", int'(anode), 3);
    @(negedge clk);
    check("release_digit0", int'(anode), 2);

    data = 6'h2A;
    repeat (2) @(negedge clk);
    wait_an(2'b10);
    check("2A_digit0", int'(cathode), 'h08);
    wait_an(2'b01);
    check("2A_digit1", int'(cathode), 'h24);
    cnt = 0;
    while (anode == 2'b01 && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    check("dwell", cnt, R);

    #2 rst = 1'b1;
    #1;
    check("async_anode", int'(anode), 3);
    check("async_cathode", int'(cathode), 'h7F);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rerelease_dark", int'(anode), 3);
    @(negedge clk);
    check("rerelease_d0", int'(anode), 2);

    data = 6'h05;
    blank_lz = 1'b1;
    repeat (2) @(negedge clk);
    wait_an(2'b01);
    check("lz_digit1", int'(cathode), 'h7F);
    wait_an(2'b10);
    check("lz_digit0", int'(cathode), 'h12);
    blank_lz = 1'b0;
    wait_an(2'b01);
    check("nolz_digit1", int'(cathode), 'h40);

    valid = 1'b0;
    @(negedge clk);
    hold = 1'b1;
    @(negedge clk);
    check("err_set", int'(err), 1);
    wait_an(2'b01);
    check("err_E", int'(cathode), 'h06);
    wait_an(2'b10);
    check("err_dash", int'(cathode), 'h3F);
    count_dark(32, 16, "blink_dark");

    hold = 1'b0;
    valid = 1'b1;
    data = 6'h11;
    repeat (3) @(negedge clk);
    check("err_clear", int'(err), 0);
    count_dark(32, 0, "no_blink");

    hold = 1'b1;
    valid = 1'b0;
    data = 6'h3F;
    repeat (10) @(negedge clk);
    check("hold_err", int'(err), 0);
    wait_an(2'b10);
    check("hold_d0", int'(cathode), 'h79);
    wait_an(2'b01);
    check("hold_d1", int'(cathode), 'h79);
    hold = 1'b0;
    @(negedge clk);
    check("unhold_err", int'(err), 1);

    valid = 1'b1;
    data = 6'h11;
    repeat (20) @(negedge clk);
    wait_change();
    repeat (3) @(negedge clk);
    data = 6'h0C;
    a_new = anode;
    @(negedge clk);
    check("wrap_switched", int'(anode != a_new), 1);
    check("wrap_old", int'(cathode), 'h79);
    a_new = anode;
    @(negedge clk);
    check("wrap_hold_digit", int'(anode), int'(a_new));
    check("wrap_new", int'(cathode),
          (a_new == 2'b10) ? 'h46 : 'h40);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      valid    = ($urandom_range(0, 9) < 8);
      hold     = ($urandom_range(0, 9) < 2);
      blank_lz = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0)
        data = DW'($urandom_range(0, 15));
      else
        data = DW'($urandom);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alsu_seg_mux_driver.md
ALSU_SEG_MUX_DRIVER -- requirements
Module: alsu_seg_mux_driver

Interface
REQ-001 Parameter DATA_W, default 6, width of the ALSU result shown; SHALL satisfy 1 <= DATA_W <= 4*DIGITS.
REQ-002 Parameter DIGITS, default 4, number of multiplexed seven-segment digits; SHALL be >= 2.
REQ-003 Parameter REFRESH_DIV, default 100000, clock cycles each digit stays lit; SHALL be >= 2.
REQ-004 Parameter BLINK_DIV, default 25000000, clock cycles per half-period of the error blink; SHALL be >= 2.
REQ-005 Ports, one per line:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- valid  input  1  ALSU result valid qualifier.
- data  input  DATA_W  ALSU result, unsigned.
- hold  input  1  freeze captured result and error flag.
- blank_lz  input  1  enable leading-zero blanking.
- anode  output  DIGITS  digit enables, active-low, one-hot-low.
- cathode  output  7  segments {g,f,e,d,c,b,a}, active-low.
- err  output  1  error flag currently latched.

Function
REQ-006 Capture: when hold=0 and valid=1, data SHALL be loaded into the display register (zero-extended to 4*DIGITS) and err cleared on the same edge.
REQ-007 When hold=0 and valid=0, err SHALL be set; the display register SHALL keep its value.
REQ-008 When hold=1, display register and err SHALL not change regardless of valid.
REQ-009 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; on wrap the digit index SHALL advance by 1, from DIGITS-1 to 0.
REQ-010 Digit i SHALL show hex nibble bits [4i+3:4i] of the display register, glyphs 0-9, A, b, C, d, E, F.
REQ-011 Leading-zero blanking: with blank_lz=1 and err=0, digit i (i>0) SHALL be blank (cathode 7'h7F) when nibbles i..DIGITS-1 are all zero; digit 0 SHALL never be blanked.
REQ-012 Error display: with err=1, digit DIGITS-1 SHALL show 'E' (7'h06), all others '-' (7'h3F); blank_lz ignored.
REQ-013 Blink: blink counter SHALL count 0..BLINK_DIV-1 and toggle blink phase on wrap; while err=1 and phase=1, anode SHALL be all ones; counter and phase SHALL run freely regardless of err.
REQ-014 anode and cathode SHALL be registered: values at edge t+1 derive from digit index, display register, err and phase as held before edge t+1 (one-cycle latency; capture at edge t is visible on outputs after edge t+1).
REQ-015 Capture coincident with refresh wrap: the new digit index SHALL be driven with the pre-capture register contents for one cycle, then the new contents.
REQ-016 Exactly one anode bit SHALL be low at any time outside reset and blink-off.

Reset
REQ-017 rst=1 SHALL asynchronously force anode=all ones, cathode=7'h7F, err=0, display register=0, digit index=0, refresh and blink counters=0, blink phase=0.
REQ-018 Reset mid-refresh or mid-blink SHALL discard all progress; first digit lit after release SHALL be digit 0 on the second edge after rst falls.

Structure
REQ-019 Hex-to-segment glyph table, error/dash/blank constants and counter-width helper function SHALL live in a shared package alsu_pkg.
REQ-020 Digit scan (refresh counter, index, anode decode) SHALL be a sub-module seg_scan_ctrl; capture, blanking, error and blink logic remain in the top.

Verification (DATA_W=6, DIGITS=2, REFRESH_DIV=4, BLINK_DIV=8)
REQ-021 rst pulse mid-scan -> anode=2'b11, cathode=7'h7F immediately; digit 0 lit on second edge after release.
REQ-022 valid=1, data=6'h2A -> digit0 cathode 7'h08 ('A'), digit1 cathode 7'h24 ('2'); anode alternates 2'b10/2'b01 every 4 cycles.
REQ-023 valid=1, data=6'h05, blank_lz=1 -> digit1 cathode 7'h7F, digit0 cathode 7'h12; blank_lz=0 -> digit1 7'h40.
REQ-024 valid=0 one cycle -> err=1, digit1 'E' 7'h06, digit0 7'h3F, anode all ones for alternate 8-cycle windows; valid=1 data=6'h11 -> err=0, blinking stops.
REQ-025 hold=1, valid=0, data=6'h3F -> err and displayed value unchanged; hold=0 -> err=1 next edge.
REQ-026 valid=1 data=6'h0C on the refresh-wrap edge -> newly selected digit shows old value one cycle, then new value.
